// File: rtl/ntt_core_gf64_pkg.sv
// Shared constants for GF(p) arithmetic with the Solinas prime p = 2^64 - 2^32 + 1.
package ntt_core_gf64_pkg;
    localparam int          MOD_NTT_W = 64;
    localparam logic [63:0] PRIME     = 64'hFFFF_FFFF_0000_0001;
    localparam int          HALF_PER  = 96;   // 2^96 == -1 (mod p)
    localparam int          FULL_PER  = 192;  // 2^192 == 1 (mod p)
    localparam int          CHUNK_W   = 32;
    localparam int          N_CHUNK   = 6;
endpackage

// File: rtl/ntt_core_gf64_pmr_shift_var_core.sv
// Single-channel shift-and-fold datapath: decompose/shift, chunk fold, final sum and sign.
module ntt_core_gf64_pmr_shift_var_core
    import ntt_core_gf64_pkg::*;
#(
    parameter int OP_W = 66
) (
    input  logic                   clk,
    input  logic [OP_W-1:0]        i_a,
    input  logic [7:0]             i_k,
    input  logic                   i_neg,
    input  logic [2:0]             i_en,
    output logic [MOD_NTT_W+1:0]   o_z
);
    localparam int SH_W = CHUNK_W * N_CHUNK;
    localparam int Z_W  = MOD_NTT_W + 2;

    logic [7:0]      w_kk;
    logic            w_half;
    logic [7:0]      w_s;
    logic [OP_W-1:0] w_mag;
    logic [SH_W-1:0] w_shift;
    logic            w_sgn;

    always_comb begin
        w_kk    = (i_k >= 8'(FULL_PER)) ? i_k - 8'(FULL_PER) : i_k;
        w_half  = (w_kk >= 8'(HALF_PER));
        w_s     = w_half ? w_kk - 8'(HALF_PER) : w_kk;
        // Unsigned magnitude: the most negative operand maps to 2^(OP_W-1) exactly.
        w_mag   = i_a[OP_W-1] ? (~i_a + OP_W'(1)) : i_a;
        w_shift = {{(SH_W-OP_W){1'b0}}, w_mag} << w_s;
        w_sgn   = i_a[OP_W-1] ^ i_neg ^ w_half;
    end

    logic [SH_W-1:0] r_shift;
    logic            r_sgn1;

    always_ff @(posedge clk) begin
        if (i_en[0]) begin
            r_shift <= w_shift;
            r_sgn1  <= w_sgn;
        end
    end

    // value == (c0 - c2 - c3 + c5) + 2^32 * (c1 + c2 - c4 - c5)  (mod p)
    logic [CHUNK_W-1:0] w_c [N_CHUNK];
    logic [34:0]        w_lo;
    logic [33:0]        w_hi;

    always_comb begin
        for (int j = 0; j < N_CHUNK; j++) w_c[j] = r_shift[j*CHUNK_W +: CHUNK_W];
        w_lo = {3'b0, w_c[0]} - {3'b0, w_c[2]} - {3'b0, w_c[3]} + {3'b0, w_c[5]};
        w_hi = {2'b0, w_c[1]} + {2'b0, w_c[2]} - {2'b0, w_c[4]} - {2'b0, w_c[5]};
    end

    logic [34:0] r_lo;
    logic [33:0] r_hi;
    logic        r_sgn2;

    always_ff @(posedge clk) begin
        if (i_en[1]) begin
            r_lo   <= w_lo;
            r_hi   <= w_hi;
            r_sgn2 <= r_sgn1;
        end
    end

    // The true sum lies strictly inside +/-2^65, so modulo-2^66 arithmetic is exact.
    logic [Z_W-1:0] w_sum;
    logic [Z_W-1:0] r_z;

    assign w_sum = {{(Z_W-35){r_lo[34]}}, r_lo} + {r_hi, 32'b0};

    always_ff @(posedge clk) begin
        if (i_en[2]) r_z <= r_sgn2 ? -w_sum : w_sum;
    end

    assign o_z = r_z;
endmodule

// File: rtl/ntt_core_gf64_pmr_shift_var.sv
// Multi-channel variable power-of-two partial modular reduction with avail/side pipeline.
module ntt_core_gf64_pmr_shift_var
    import ntt_core_gf64_pkg::*;
#(
    parameter int         PSI       = 4,
    parameter int         OP_W      = 66,
    parameter int         MOD_NTT_W = 64,
    parameter int         IN_PIPE   = 1,
    parameter int         SIDE_W    = 1,
    parameter logic [1:0] RST_SIDE  = 2'b00
) (
    input  logic                          clk,
    input  logic                          s_rst_n,
    input  logic [PSI*OP_W-1:0]           i_a,
    input  logic [PSI*8-1:0]              i_k,
    input  logic [PSI-1:0]                i_neg,
    input  logic                          i_in_avail,
    input  logic [SIDE_W-1:0]             i_in_side,
    output logic [PSI*(MOD_NTT_W+2)-1:0]  o_z,
    output logic                          o_out_avail,
    output logic [SIDE_W-1:0]             o_out_side
);
    localparam int LAT = IN_PIPE + 3;
    localparam int Z_W = MOD_NTT_W + 2;
    localparam bit                SIDE_RST = (RST_SIDE != 2'b00);
    localparam logic [SIDE_W-1:0] SIDE_RV  = (RST_SIDE == 2'b10) ? '1 : '0;

    if (MOD_NTT_W != 64) begin : g_bad_mod_w
        $error("ntt_core_gf64_pmr_shift_var: MOD_NTT_W must be 64");
    end
    if (OP_W < 2 || OP_W > MOD_NTT_W + 2) begin : g_bad_op_w
        $error("ntt_core_gf64_pmr_shift_var: OP_W out of range");
    end

    logic [LAT:0] w_vld;
    logic [LAT:1] r_vld_pipe;

    assign w_vld = {r_vld_pipe, i_in_avail};

    always_ff @(posedge clk) begin
        if (!s_rst_n) r_vld_pipe <= '0;
        else          r_vld_pipe <= w_vld[LAT-1:0];
    end

    assign o_out_avail = w_vld[LAT];

    logic [SIDE_W-1:0] w_side [LAT+1];
    assign w_side[0] = i_in_side;

    for (genvar j = 1; j <= LAT; j++) begin : g_side
        logic [SIDE_W-1:0] r_side;
        always_ff @(posedge clk) begin
            if (SIDE_RST && !s_rst_n) r_side <= SIDE_RV;
            else if (w_vld[j-1])      r_side <= w_side[j-1];
        end
        assign w_side[j] = r_side;
    end

    assign o_out_side = w_side[LAT];

    logic [PSI-1:0][OP_W-1:0] w_a;
    logic [PSI-1:0][7:0]      w_k;
    logic [PSI-1:0]           w_neg;

    if (IN_PIPE != 0) begin : g_in_pipe
        logic [PSI-1:0][OP_W-1:0] r_a;
        logic [PSI-1:0][7:0]      r_k;
        logic [PSI-1:0]           r_neg;
        always_ff @(posedge clk) begin
            if (i_in_avail) begin
                r_a   <= i_a;
                r_k   <= i_k;
                r_neg <= i_neg;
            end
        end
        assign w_a   = r_a;
        assign w_k   = r_k;
        assign w_neg = r_neg;
    end else begin : g_in_direct
        assign w_a   = i_a;
        assign w_k   = i_k;
        assign w_neg = i_neg;
    end

    logic [2:0]              w_en;
    logic [PSI-1:0][Z_W-1:0] w_z;

    assign w_en = {w_vld[IN_PIPE+2], w_vld[IN_PIPE+1], w_vld[IN_PIPE]};

    for (genvar c = 0; c < PSI; c++) begin : g_ch
        ntt_core_gf64_pmr_shift_var_core #(.OP_W(OP_W)) u_core (
            .clk   (clk),
            .i_a   (w_a[c]),
            .i_k   (w_k[c]),
            .i_neg (w_neg[c]),
            .i_en  (w_en),
            .o_z   (w_z[c])
        );
    end

    assign o_z = w_z;
endmodule

// File: doc/ntt_core_gf64_pmr_shift_var.md
# ntt_core_gf64_pmr_shift_var

Multi-channel, runtime-controlled partial modular reduction of a signed operand multiplied by a power of two, modulo the Solinas prime p = 2^64 − 2^32 + 1. It is the variable-shift successor of the constant-shift PMR. It sits in the GF64 NTT arithmetic after butterflies, where twiddles that are powers of two (2^k, 0 ≤ k < 192, since 2^96 ≡ −1 and 2^192 ≡ 1) are applied by shift-and-fold instead of a multiplier. Fixed-latency pipeline with avail/side tagging and no backpressure.

## Interface
- PSI, default 4, number of independent channels processed per cycle.
- OP_W, default 66, input operand width, two's complement, 2 ≤ OP_W ≤ MOD_NTT_W+2.
- MOD_NTT_W, default 64, modulus width; only 64 is legal (elaboration assertion).
- IN_PIPE, default 1, 1 = register inputs before the datapath.
- SIDE_W, default 1, side-band width.
- RST_SIDE, default 2'b00, side reset: 00 none, 01 to 0, 10 to 1.
- clk  in  1  clock.
- s_rst_n  in  1  synchronous reset, active low.
- a  in  PSI*OP_W  per-channel signed operands.
- k  in  PSI*8  per-channel shift exponent, interpreted modulo 192.
- neg  in  PSI  per-channel extra negation.
- in_avail  in  1  input valid for all channels.
- in_side  in  SIDE_W  side-band travelling with the data.
- z  out  PSI*(MOD_NTT_W+2)  per-channel signed partially reduced result.
- out_avail  out  1  output valid.
- out_side  out  SIDE_W  delayed in_side.

## Operation
- Per channel: z ≡ (−1)^neg · a · 2^(k mod 192) (mod p). z is two's complement with |z| < 2^65, which is not necessarily canonical.
- Shift decomposition: kk = k mod 192 (k ≥ 192 gives k − 192). If kk ≥ 96, the sign is inverted and s = kk − 96; otherwise s = kk. Effective sign = sign(a) XOR neg XOR (kk ≥ 96).
- The magnitude |a| · 2^s (< 2^161) is split into 32-bit chunks c0..c5. Fold with 2^64 ≡ 2^32 − 1, 2^96 ≡ −1, 2^128 ≡ −2^32, 2^160 ≡ −2^32 + 1. Sum with signed arithmetic, then apply the effective sign.
- Most negative input (−2^(OP_W−1)) is handled exactly; there is no saturation.
- Channels are fully independent; k and neg may differ per channel in the same cycle.
- Data registers load only when avail is high at that stage. Otherwise they hold.

## Timing
- LATENCY = IN_PIPE + 3 cycles from in_avail to out_avail. Stages: [in reg] → decompose + barrel shift → chunk fold → final sum + sign.
- Throughput is 1 operation per cycle per channel. in_avail may be high every cycle or in any sparse pattern; the output pattern is the input pattern delayed by LATENCY.
- During reset: all avail pipeline flops are 0, so out_avail = 0. Side flops reset per RST_SIDE. Data flops are not reset, and z is don't-care while out_avail = 0.
- Reset asserted mid-stream: all in-flight items are discarded and out_avail is 0 from the cycle after the reset edge until new inputs traverse the pipe. No stale output may appear after reset release.
- out_side equals in_side of the same item.

## Structure
- Shared package ntt_core_gf64_pkg: MOD_NTT_W, the prime constant, the half-period constant 96, the full period 192, and the chunk width 32.
- One natural sub-module, ntt_core_gf64_pmr_shift_var_core: a single-channel datapath without avail/side, instantiated PSI times. The top owns the avail/side pipeline and the shared IN_PIPE registers.

## Test plan
- a=1, k=0, neg=0 → z ≡ 1. a=1, k=96 → z ≡ 0xFFFFFFFF00000000 (p−1).
- a=1, k=191 → z ≡ 0x7FFFFFFF80000001 (2^−1 mod p). a=1, k=200 → same as k=8 → z ≡ 0x100.
- a=−1 (all ones), k=64, neg=0 → z ≡ 0xFFFFFFFE00000002. Same with neg=1 → z ≡ 0xFFFFFFFF.
- OP_W=66, a=−2^65, all k in 0..191, neg in {0,1}, PSI channels with different k → each reduced z matches the model, and |z| < 2^65 is checked.
- Random a/k/neg for 10^6 items with random in_avail gaps, side = item index → exact out_avail pattern at LATENCY; side and reduced results match in order.
- Reset pulsed with items in flight → out_avail stays 0 until the first post-reset item arrives at LATENCY; no spurious outputs. Side reset value checked for RST_SIDE = 01 and 10.
